// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key event sequencer: folds E0/F0 prefixes into {release, extended, scancode} events, filters typematic repeats, and buffers the events.
// Latency: an event is visible on ev_valid/ev_data one CLK cycle after its final byte is sampled.
// Backpressure: valid/ready on the event side; when the FIFO is full a new event is dropped and the sticky overflow flag is raised.
//
// Ports:
//   CLK, reset    - clock and synchronous active-high reset
//   code          - receiver byte; a nonzero value held for one cycle is one received byte
//   ev_ready      - consumer pops the head event
//   ev_valid      - FIFO not empty
//   ev_data       - head event, zero when empty
//   ev_count      - number of buffered events
//   overflow      - sticky "event dropped" flag
//   busy          - a prefix is pending

// Small synchronous FIFO. A pop in the same cycle frees a slot for a push into a full FIFO.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: a push into a full FIFO without a pop is dropped and flagged on drop.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // Full FIFO still accepts a push when a pop frees a slot on the same edge.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !pop;
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module ps2_key_event_ctrl #(
  parameter int DEPTH         = 4,
  parameter int TIMEOUT       = 100000,
  parameter int FILTER_REPEAT = 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [7:0]             code,
  input  logic                   ev_ready,
  output logic                   ev_valid,
  output logic [9:0]             ev_data,
  output logic [$clog2(DEPTH):0] ev_count,
  output logic                   overflow,
  output logic                   busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

  state_t        state;
  state_t        nxt_state;
  logic [CW-1:0] tmo_cnt;
  logic [8:0]    last_make;
  logic          held;
  logic          byte_vld;
  logic          emit;
  logic          ev_rel;
  logic          ev_ext;
  logic          suppress;
  logic          push;
  logic          fifo_drop;

  assign byte_vld = (code != 8'h00);

  // Decode of the current byte against the pending prefix; the event is pushed on this same edge.
  always_comb begin
    nxt_state = state;
    emit      = 1'b0;
    ev_rel    = 1'b0;
    ev_ext    = 1'b0;
    if (byte_vld) begin
      case (state)
        IDLE: begin
          if (code == 8'hE0)      nxt_state = ST_E0;
          else if (code == 8'hF0) nxt_state = ST_F0;
          else if (!(code inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'hE1})) emit = 1'b1;
        end
        ST_E0: begin
          if (code == 8'hF0)      nxt_state = ST_E0F0;
          else if (code == 8'hE0) nxt_state = ST_E0;
          else begin
            emit = 1'b1; ev_ext = 1'b1; nxt_state = IDLE;
          end
        end
        ST_F0: begin
          // E0 after F0 is out of order but still read as an extended release.
          if (code == 8'hF0)      nxt_state = ST_F0;
          else if (code == 8'hE0) nxt_state = ST_E0F0;
          else begin
            emit = 1'b1; ev_rel = 1'b1; nxt_state = IDLE;
          end
        end
        default: begin
          if (code == 8'hE0 || code == 8'hF0) nxt_state = ST_E0F0;
          else begin
            emit = 1'b1; ev_rel = 1'b1; ev_ext = 1'b1; nxt_state = IDLE;
          end
        end
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_LAST) begin
      // Stale prefix; a byte on this cycle would have taken priority above.
      nxt_state = IDLE;
    end
  end

  // A make of the key that is still held is a typematic repeat.
  assign suppress = (FILTER_REPEAT != 0) && !ev_rel && held && (last_make == {ev_ext, code});
  assign push     = emit && !suppress;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      last_make <= '0;
      held      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= nxt_state;
      if (byte_vld)                                 tmo_cnt <= '0;
      else if (state != IDLE && tmo_cnt == TMO_LAST) tmo_cnt <= '0;
      else if (state != IDLE)                       tmo_cnt <= tmo_cnt + 1'b1;
      // Held-key tracking follows produced events even when the FIFO drops them.
      if (emit) begin
        if (!ev_rel) begin
          if (!suppress) begin
            last_make <= {ev_ext, code};
            held      <= 1'b1;
          end
        end else if (last_make == {ev_ext, code}) begin
          held <= 1'b0;
        end
      end
      if (fifo_drop) overflow <= 1'b1;
    end
  end

  assign busy     = (state != IDLE);
  assign ev_valid = (ev_count != '0);

  ps2_event_fifo #(.WIDTH(10), .DEPTH(DEPTH)) u_fifo (
    .CLK      (CLK),
    .reset    (reset),
    .push     (push),
    .push_dat ({ev_rel, ev_ext, code}),
    .pop      (ev_ready),
    .head_dat (ev_data),
    .count    (ev_count),
    .drop     (fifo_drop)
  );
endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;
  localparam int DA  = 4;
  localparam int DB  = 8;
  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] code = 8'h00;
  logic       ev_ready = 1'b0;

  logic       ev_valid_a, overflow_a, busy_a;
  logic [9:0] ev_data_a;
  logic [2:0] ev_count_a;
  logic       ev_valid_b, overflow_b, busy_b;
  logic [9:0] ev_data_b;
  logic [3:0] ev_count_b;

  int checks = 0;
  int errors = 0;

  // Reference model: prefixes accumulate as flags, events go into queues.
  bit         m_pend, m_ext, m_rel;
  int         m_gap;
  logic [9:0] mq_a[$];
  logic [9:0] mq_b[$];
  bit         m_held[2];
  logic [8:0] m_last[2];
  bit         m_ovf[2];

  always #5 CLK = ~CLK;

  ps2_key_event_ctrl #(.DEPTH(DA), .TIMEOUT(TMO), .FILTER_REPEAT(1)) dut (
    .CLK(CLK), .reset(reset), .code(code), .ev_ready(ev_ready),
    .ev_valid(ev_valid_a), .ev_data(ev_data_a), .ev_count(ev_count_a),
    .overflow(overflow_a), .busy(busy_a)
  );

  ps2_key_event_ctrl #(.DEPTH(DB), .TIMEOUT(TMO), .FILTER_REPEAT(0)) dut_nf (
    .CLK(CLK), .reset(reset), .code(code), .ev_ready(ev_ready),
    .ev_valid(ev_valid_b), .ev_data(ev_data_b), .ev_count(ev_count_b),
    .overflow(overflow_b), .busy(busy_b)
  );

  task automatic model_clear();
    m_pend = 0; m_ext = 0; m_rel = 0; m_gap = 0;
    mq_a.delete(); mq_b.delete();
    for (int k = 0; k < 2; k++) begin
      m_held[k] = 0; m_last[k] = '0; m_ovf[k] = 0;
    end
  endtask

  task automatic model_enq(input int k, input logic [9:0] ev);
    if (k == 0) begin
      if (mq_a.size() < DA) mq_a.push_back(ev); else m_ovf[0] = 1'b1;
    end else begin
      if (mq_b.size() < DB) mq_b.push_back(ev); else m_ovf[1] = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance the model, sample #1 after the edge.
  task automatic cycle(input logic [7:0] c, input bit rdy);
    logic [9:0] ev;
    bit emit;
    @(negedge CLK);
    code = c; ev_ready = rdy;
    if (rdy && mq_a.size() > 0) void'(mq_a.pop_front());
    if (rdy && mq_b.size() > 0) void'(mq_b.pop_front());
    emit = 0; ev = '0;
    if (c != 8'h00) begin
      if (m_pend && m_gap >= TMO) begin m_pend = 0; m_ext = 0; m_rel = 0; end
      m_gap = 0;
      if (c == 8'hE0) begin m_pend = 1; m_ext = 1; end
      else if (c == 8'hF0) begin m_pend = 1; m_rel = 1; end
      else if (!m_pend && (c inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'hE1})) emit = 0;
      else begin
        ev = {m_rel, m_ext, c}; emit = 1;
        m_pend = 0; m_ext = 0; m_rel = 0;
      end
    end else if (m_gap < 1000000) begin
      m_gap++;
    end
    if (emit) begin
      for (int k = 0; k < 2; k++) begin
        if (!ev[9]) begin
          if (!(k == 0 && m_held[k] && m_last[k] == ev[8:0])) begin
            m_last[k] = ev[8:0]; m_held[k] = 1; model_enq(k, ev);
          end
        end else begin
          if (m_last[k] == ev[8:0]) m_held[k] = 0;
          model_enq(k, ev);
        end
      end
    end
    @(posedge CLK); #1;
    code = 8'h00; ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b1; code = 8'h00; ev_ready = 1'b0;
    @(posedge CLK); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ev_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ev_valid_a); end
    checks++; if (ev_data_a !== 10'h000) begin errors++; $display("FAIL reset_data got %h exp 000", ev_data_a); end
    checks++; if (ev_count_a !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ev_count_a); end
    checks++; if (overflow_a !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
  endtask

  task automatic test_plain();
    do_reset();
    cycle(8'h1C, 0);
    checks++; if ({ev_valid_a, ev_data_a, ev_count_a} !== {1'b1, 10'h01C, 3'd1}) begin errors++; $display("FAIL plain_make got v%b d%h c%0d exp v1 d01c c1", ev_valid_a, ev_data_a, ev_count_a); end
    cycle(8'hF0, 0);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL plain_busy got %b exp 1", busy_a); end
    cycle(8'h1C, 0);
    checks++; if ({ev_data_a, ev_count_a} !== {10'h01C, 3'd2}) begin errors++; $display("FAIL plain_two got d%h c%0d exp d01c c2", ev_data_a, ev_count_a); end
    cycle(8'h00, 1);
    checks++; if ({ev_data_a, ev_count_a} !== {10'h21C, 3'd1}) begin errors++; $display("FAIL plain_break got d%h c%0d exp d21c c1", ev_data_a, ev_count_a); end
    cycle(8'h00, 1);
    checks++; if ({ev_valid_a, ev_data_a} !== {1'b0, 10'h000}) begin errors++; $display("FAIL plain_drain got v%b d%h exp v0 d000", ev_valid_a, ev_data_a); end
  endtask

  task automatic test_extended();
    do_reset();
    cycle(8'hE0, 0);
    checks++; if ({busy_a, ev_valid_a} !== 2'b10) begin errors++; $display("FAIL ext_prefix got busy%b v%b exp busy1 v0", busy_a, ev_valid_a); end
    cycle(8'h75, 0);
    checks++; if ({busy_a, ev_data_a} !== {1'b0, 10'h175}) begin errors++; $display("FAIL ext_make got busy%b d%h exp busy0 d175", busy_a, ev_data_a); end
    cycle(8'hE0, 0);
    cycle(8'hF0, 0);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL ext_break_busy got %b exp 1", busy_a); end
    cycle(8'h75, 0);
    cycle(8'h00, 1);
    checks++; if ({ev_data_a, ev_count_a, busy_a} !== {10'h375, 3'd1, 1'b0}) begin errors++; $display("FAIL ext_break got d%h c%0d busy%b exp d375 c1 busy0", ev_data_a, ev_count_a, busy_a); end
    // F0 then E0 is accepted as an extended release.
    cycle(8'h00, 1);
    cycle(8'hF0, 0); cycle(8'hE0, 0); cycle(8'h6B, 0);
    checks++; if (ev_data_a !== 10'h36B) begin errors++; $display("FAIL ext_f0e0 got %h exp 36b", ev_data_a); end
  endtask

  task automatic test_repeat();
    logic [9:0] exp_seq [3];
    logic [9:0] src;
    exp_seq[0] = 10'h01C; exp_seq[1] = 10'h21C; exp_seq[2] = 10'h01C;
    do_reset();
    cycle(8'h1C, 0); cycle(8'h1C, 0); cycle(8'h1C, 0);
    cycle(8'hF0, 0); cycle(8'h1C, 0); cycle(8'h1C, 0);
    checks++; if (ev_count_a !== 3'd3) begin errors++; $display("FAIL repeat_count_filtered got %0d exp 3", ev_count_a); end
    checks++; if (ev_count_b !== 4'd5) begin errors++; $display("FAIL repeat_count_unfiltered got %0d exp 5", ev_count_b); end
    for (int i = 0; i < 3; i++) begin
      src = ev_data_a;
      checks++; if (src !== exp_seq[i]) begin errors++; $display("FAIL repeat_seq%0d got %h exp %h", i, src, exp_seq[i]); end
      cycle(8'h00, 1);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cycle(8'hE0, 0);
    repeat (TMO - 1) cycle(8'h00, 0);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL tmo_before got busy %b exp 1", busy_a); end
    cycle(8'h00, 0);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL tmo_expired got busy %b exp 0", busy_a); end
    cycle(8'h75, 0);
    checks++; if ({ev_data_a, ev_count_a} !== {10'h075, 3'd1}) begin errors++; $display("FAIL tmo_after got d%h c%0d exp d075 c1", ev_data_a, ev_count_a); end
    // A byte landing on the timeout cycle still completes the prefix.
    do_reset();
    cycle(8'hE0, 0);
    repeat (TMO - 1) cycle(8'h00, 0);
    cycle(8'h75, 0);
    checks++; if (ev_data_a !== 10'h175) begin errors++; $display("FAIL tmo_edge got %h exp 175", ev_data_a); end
    do_reset();
    cycle(8'hAA, 0); cycle(8'hFA, 0);
    checks++; if ({ev_valid_a, ev_count_a} !== {1'b0, 3'd0}) begin errors++; $display("FAIL ignore_bytes got v%b c%0d exp v0 c0", ev_valid_a, ev_count_a); end
  endtask

  task automatic test_overflow();
    logic [7:0] keys [5];
    keys[0] = 8'h15; keys[1] = 8'h1D; keys[2] = 8'h24; keys[3] = 8'h2D; keys[4] = 8'h2C;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(keys[i], 0);
    cycle(8'h1B, 1);
    checks++; if ({ev_count_a, overflow_a, ev_data_a} !== {3'd4, 1'b0, 10'h01D}) begin errors++; $display("FAIL full_pushpop got c%0d o%b d%h exp c4 o0 d01d", ev_count_a, overflow_a, ev_data_a); end
    do_reset();
    for (int i = 0; i < 5; i++) cycle(keys[i], 0);
    checks++; if ({ev_count_a, overflow_a, ev_data_a} !== {3'd4, 1'b1, 10'h015}) begin errors++; $display("FAIL overflow got c%0d o%b d%h exp c4 o1 d015", ev_count_a, overflow_a, ev_data_a); end
    cycle(8'h1B, 1);
    checks++; if ({ev_count_a, overflow_a, ev_data_a} !== {3'd4, 1'b1, 10'h01D}) begin errors++; $display("FAIL overflow_pushpop got c%0d o%b d%h exp c4 o1 d01d", ev_count_a, overflow_a, ev_data_a); end
    do_reset();
    cycle(8'h1C, 1);
    checks++; if ({ev_valid_a, ev_count_a} !== {1'b1, 3'd1}) begin errors++; $display("FAIL empty_pushpop got v%b c%0d exp v1 c1", ev_valid_a, ev_count_a); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(8'h10 + 8'(i), 0);
    cycle(8'hE0, 0); cycle(8'hF0, 0);
    do_reset();
    checks++; if ({ev_count_a, overflow_a, busy_a} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL midreset got c%0d o%b busy%b exp c0 o0 busy0", ev_count_a, overflow_a, busy_a); end
    cycle(8'h75, 0);
    checks++; if ({ev_data_a, ev_count_a} !== {10'h075, 3'd1}) begin errors++; $display("FAIL midreset_after got d%h c%0d exp d075 c1", ev_data_a, ev_count_a); end
  endtask

  task automatic test_random();
    logic [7:0] pool_key [4];
    logic [7:0] pool_sp [6];
    logic [7:0] c;
    logic [9:0] ea, eb;
    int r;
    bit rdy;
    pool_key[0] = 8'h1C; pool_key[1] = 8'h1D; pool_key[2] = 8'h75; pool_key[3] = 8'h15;
    pool_sp[0] = 8'hAA; pool_sp[1] = 8'hFA; pool_sp[2] = 8'hEE;
    pool_sp[3] = 8'hFC; pool_sp[4] = 8'hFE; pool_sp[5] = 8'hE1;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 19);
      if (r < 7) c = 8'h00;
      else if (r < 9) c = 8'hE0;
      else if (r < 11) c = 8'hF0;
      else if (r < 12) c = pool_sp[$urandom_range(0, 5)];
      else c = pool_key[$urandom_range(0, 3)];
      rdy = ($urandom_range(0, 2) == 0);
      if (r == 19) begin
        repeat ($urandom_range(TMO - 2, TMO + 2)) cycle(8'h00, rdy);
        c = pool_key[$urandom_range(0, 3)];
      end
      cycle(c, rdy);
      ea = (mq_a.size() > 0) ? mq_a[0] : 10'h000;
      eb = (mq_b.size() > 0) ? mq_b[0] : 10'h000;
      checks++;
      if ({ev_valid_a, ev_data_a, ev_count_a, overflow_a, busy_a} !==
          {mq_a.size() > 0, ea, 3'(mq_a.size()), m_ovf[0], m_pend && m_gap < TMO}) begin
        errors++;
        $display("FAIL rand_a cyc%0d got v%b d%h c%0d o%b b%b exp v%b d%h c%0d o%b b%b", n,
                 ev_valid_a, ev_data_a, ev_count_a, overflow_a, busy_a,
                 mq_a.size() > 0, ea, mq_a.size(), m_ovf[0], m_pend && m_gap < TMO);
      end
      checks++;
      if ({ev_valid_b, ev_data_b, ev_count_b, overflow_b} !== {mq_b.size() > 0, eb, 4'(mq_b.size()), m_ovf[1]}) begin
        errors++;
        $display("FAIL rand_b cyc%0d got v%b d%h c%0d o%b exp v%b d%h c%0d o%b", n,
                 ev_valid_b, ev_data_b, ev_count_b, overflow_b, mq_b.size() > 0, eb, mq_b.size(), m_ovf[1]);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_plain();
    test_extended();
    test_repeat();
    test_timeout();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
